// File: rtl/bram_pkg.sv
// bram_pkg: shared constants and lane-replication helper for the bram_sp block RAM.
package bram_pkg;

    // One lane is 8 data bits plus 1 parity bit
    localparam int unsigned LANE_W    = 9;
    localparam int unsigned MAX_LANES = 32;

    // Write-mode encodings
    localparam int unsigned WM_WRITE_FIRST = 0;
    localparam int unsigned WM_READ_FIRST  = 1;
    localparam int unsigned WM_NO_CHANGE   = 2;

    // Replicate a 9-bit lane value across 'lanes' lanes in {parity[lanes-1:0], data[8*lanes-1:0]} layout.
    // The caller truncates the result to its real word width.
    function automatic logic [LANE_W*MAX_LANES-1:0] lane_fill(input logic [LANE_W-1:0] v,
                                                              input int unsigned       lanes);
        logic [LANE_W*MAX_LANES-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            if (k < lanes) begin
                w[8*k +: 8]      = v[7:0];
                w[8*lanes + k]   = v[8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bram_out_stage.sv
// bram_out_stage: output latch plus optional DO register, both loaded with SRVAL by SSR.
// Optional feature macro: BRAM_DOREG_EN adds the second output register (read latency 2).
module bram_out_stage
    import bram_pkg::*;
#(
    parameter int unsigned        WORD_W = LANE_W,
    parameter logic [WORD_W-1:0]  SRVAL  = '0
) (
    input  logic              clk_i,
    input  logic              ssr_i,
    input  logic              ld_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] latch_q = SRVAL;
    logic [WORD_W-1:0] latch_d;

    // Latch next value: load on request, otherwise hold
    always_comb begin
        latch_d = latch_q;
        if (ld_i) begin
            latch_d = d_i;
        end
    end

    // Output latch; SSR wins over any load
    always_ff @(posedge clk_i) begin
        if (ssr_i) begin
            latch_q <= SRVAL;
        end else begin
            latch_q <= latch_d;
        end
    end

`ifdef BRAM_DOREG_EN
    logic [WORD_W-1:0] doreg_q = SRVAL;

    // Pipeline register follows the latch every clock
    always_ff @(posedge clk_i) begin
        if (ssr_i) begin
            doreg_q <= SRVAL;
        end else begin
            doreg_q <= latch_q;
        end
    end

    assign q_o = doreg_q;
`else
    assign q_o = latch_q;
`endif

endmodule

// File: rtl/bram_sp.sv
// bram_sp: parametrised single-port block RAM (default 2Kx9) with byte-lane writes and
// WRITE_FIRST / READ_FIRST / NO_CHANGE read-during-write behaviour.
// Optional feature macro: BRAM_DOREG_EN (extra output register, latency 2).
module bram_sp
    import bram_pkg::*;
#(
    parameter int unsigned                ADDR_W     = 11,
    parameter int unsigned                LANES      = 1,
    parameter int unsigned                WRITE_MODE = WM_WRITE_FIRST,
    parameter logic [LANE_W*LANES-1:0]    SRVAL      = (LANE_W*LANES)'(lane_fill(9'h000, LANES)),
    parameter logic [LANE_W-1:0]          INIT_FILL  = 9'h15A
) (
    input  logic                 CLK,
    input  logic                 SSR,
    input  logic                 EN,
    input  logic [LANES-1:0]     WE,
    input  logic [ADDR_W-1:0]    ADDR,
    input  logic [8*LANES-1:0]   DI,
    input  logic [LANES-1:0]     DIP,
    output logic [8*LANES-1:0]   DO,
    output logic [LANES-1:0]     DOP
);

    localparam int unsigned DATA_W = 8 * LANES;
    localparam int unsigned WORD_W = LANE_W * LANES;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [WORD_W-1:0] INIT_WORD = WORD_W'(lane_fill(INIT_FILL, LANES));

    if (WRITE_MODE > WM_NO_CHANGE) begin : g_bad_mode
        $error("bram_sp: unsupported WRITE_MODE %0d", WRITE_MODE);
    end

    // Words are stored as {parity[LANES-1:0], data[DATA_W-1:0]} so they map straight onto {DOP,DO}
    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: INIT_WORD};

    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] lat_d;
    logic              lat_ld;
    logic [WORD_W-1:0] dout;

    assign rd_word = mem_q[ADDR];

    // Lane write masking: written lanes take DI/DIP, others keep stored content
    always_comb begin
        wr_word = rd_word;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (WE[k]) begin
                wr_word[8*k +: 8]    = DI[8*k +: 8];
                wr_word[DATA_W + k]  = DIP[k];
            end
        end
    end

    // Write-mode mux: choose what the output latch sees and whether it loads
    always_comb begin
        lat_d  = rd_word;
        lat_ld = EN;
        if (WRITE_MODE == WM_WRITE_FIRST) begin
            lat_d = wr_word;
        end else if (WRITE_MODE == WM_NO_CHANGE) begin
            lat_ld = EN & ~(|WE);
        end
    end

    // Array write; SSR only affects the output path, so writes still commit
    always_ff @(posedge CLK) begin
        if (EN && (|WE)) begin
            mem_q[ADDR] <= wr_word;
        end
    end

    bram_out_stage #(
        .WORD_W (WORD_W),
        .SRVAL  (SRVAL)
    ) u_out (
        .clk_i (CLK),
        .ssr_i (SSR),
        .ld_i  (lat_ld),
        .d_i   (lat_d),
        .q_o   (dout)
    );

    assign DO  = dout[DATA_W-1:0];
    assign DOP = dout[WORD_W-1:DATA_W];

endmodule

// File: tb/tb_bram_sp.sv
// tb_bram_sp: scoreboard bench for bram_sp; three instances cover the three write modes.
module tb_bram_sp;

`ifdef BRAM_DOREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    localparam logic [17:0] SRV_WF = 18'h00000;
    localparam logic [17:0] SRV_RF = 18'h00000;
    localparam logic [17:0] SRV_NC = 18'h001FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WRITE_FIRST, 2 lanes
    logic        wf_ssr, wf_en;
    logic [1:0]  wf_we, wf_dip, wf_dop;
    logic [10:0] wf_addr;
    logic [15:0] wf_di, wf_do;
    // READ_FIRST, 1 lane
    logic        rf_ssr, rf_en, rf_we, rf_dip, rf_dop;
    logic [10:0] rf_addr;
    logic [7:0]  rf_di, rf_do;
    // NO_CHANGE, 1 lane, SRVAL 9'h1FF
    logic        nc_ssr, nc_en, nc_we, nc_dip, nc_dop;
    logic [10:0] nc_addr;
    logic [7:0]  nc_di, nc_do;

    bram_sp #(.LANES(2), .WRITE_MODE(0)) u_wf (
        .CLK(clk), .SSR(wf_ssr), .EN(wf_en), .WE(wf_we), .ADDR(wf_addr),
        .DI(wf_di), .DIP(wf_dip), .DO(wf_do), .DOP(wf_dop)
    );

    bram_sp #(.LANES(1), .WRITE_MODE(1)) u_rf (
        .CLK(clk), .SSR(rf_ssr), .EN(rf_en), .WE(rf_we), .ADDR(rf_addr),
        .DI(rf_di), .DIP(rf_dip), .DO(rf_do), .DOP(rf_dop)
    );

    bram_sp #(.LANES(1), .WRITE_MODE(2), .SRVAL(9'h1FF)) u_nc (
        .CLK(clk), .SSR(nc_ssr), .EN(nc_en), .WE(nc_we), .ADDR(nc_addr),
        .DI(nc_di), .DIP(nc_dip), .DO(nc_do), .DOP(nc_dop)
    );

    // One entry per instance per clock: expected latch value after that edge
    typedef struct {
        logic        chk;
        logic        ssr;
        logic [17:0] lat;
        string       tag;
    } exp_t;

    exp_t q_wf[$];
    exp_t q_rf[$];
    exp_t q_nc[$];

    logic [17:0] lat_wf, lat_rf, lat_nc;
    logic        chk_wf, chk_rf, chk_nc;
    string       tag_wf, tag_rf, tag_nc;
    logic        done = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected DO/DOP given the expected latch sequence
    function automatic logic [17:0] dout_model(input exp_t e, input logic [17:0] prev,
                                               input logic [17:0] srv);
        if (LAT == 1) return e.lat;
        return e.ssr ? srv : prev;
    endfunction

    // Monitor: pops one expectation per instance each clock and compares away from the edge
    initial begin
        exp_t        e;
        logic [17:0] prev_wf, prev_rf, prev_nc;
        prev_wf = SRV_WF;
        prev_rf = SRV_RF;
        prev_nc = SRV_NC;
        #1;
        check("pwr_wf", {wf_dop, wf_do}, SRV_WF);
        check("pwr_rf", {9'h000, rf_dop, rf_do}, SRV_RF);
        check("pwr_nc", {9'h000, nc_dop, nc_do}, SRV_NC);
        forever begin
            @(negedge clk);
            if (q_wf.size() != 0) begin
                e = q_wf.pop_front();
                if (e.chk) check(e.tag, {wf_dop, wf_do}, dout_model(e, prev_wf, SRV_WF));
                prev_wf = e.lat;
            end
            if (q_rf.size() != 0) begin
                e = q_rf.pop_front();
                if (e.chk) check(e.tag, {9'h000, rf_dop, rf_do}, dout_model(e, prev_rf, SRV_RF));
                prev_rf = e.lat;
            end
            if (q_nc.size() != 0) begin
                e = q_nc.pop_front();
                if (e.chk) check(e.tag, {9'h000, nc_dop, nc_do}, dout_model(e, prev_nc, SRV_NC));
                prev_nc = e.lat;
            end
            if (done && q_wf.size() == 0 && q_rf.size() == 0 && q_nc.size() == 0) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // Push this cycle's expectations, then advance one clock
    task automatic cyc();
        q_wf.push_back('{chk_wf, wf_ssr, lat_wf, tag_wf});
        q_rf.push_back('{chk_rf, rf_ssr, lat_rf, tag_rf});
        q_nc.push_back('{chk_nc, nc_ssr, lat_nc, tag_nc});
        @(posedge clk);
        #1;
        chk_wf = 1'b0;
        chk_rf = 1'b0;
        chk_nc = 1'b0;
    endtask

    // Directed stimulus with hand-computed latch values
    initial begin
        wf_ssr = 0; wf_en = 0; wf_we = '0; wf_addr = '0; wf_di = '0; wf_dip = '0;
        rf_ssr = 0; rf_en = 0; rf_we = 0;  rf_addr = '0; rf_di = '0; rf_dip = 0;
        nc_ssr = 0; nc_en = 0; nc_we = 0;  nc_addr = '0; nc_di = '0; nc_dip = 0;
        lat_wf = SRV_WF; lat_rf = SRV_RF; lat_nc = SRV_NC;
        chk_wf = 0; chk_rf = 0; chk_nc = 0;
        tag_wf = "wf"; tag_rf = "rf"; tag_nc = "nc";
        #1;

        // Power-up content at both ends of the address range
        rf_en = 1; rf_addr = 11'h000; lat_rf = 18'h15A; chk_rf = 1; tag_rf = "rf_pwr_000"; cyc();
        rf_addr = 11'h7FF; lat_rf = 18'h15A; chk_rf = 1; tag_rf = "rf_pwr_7ff"; cyc();

        // READ_FIRST: old data on the write edge, new data on the next read
        rf_addr = 11'd3; rf_we = 1; rf_di = 8'hAA; rf_dip = 0;
        lat_rf = 18'h15A; chk_rf = 1; tag_rf = "rf_wr_old"; cyc();
        rf_we = 0; lat_rf = 18'h0AA; chk_rf = 1; tag_rf = "rf_rd_new"; cyc();
        rf_en = 0;

        // WRITE_FIRST, per-lane enables
        wf_en = 1; wf_addr = 11'd5; wf_we = 2'b01; wf_di = 16'hBEEF; wf_dip = 2'b10;
        lat_wf = 18'h25AEF; chk_wf = 1; tag_wf = "wf_wr_lane0"; cyc();
        wf_we = 2'b00; lat_wf = 18'h25AEF; chk_wf = 1; tag_wf = "wf_rd_lane0"; cyc();
        wf_we = 2'b10; wf_di = 16'h1234; wf_dip = 2'b01;
        lat_wf = 18'h012EF; chk_wf = 1; tag_wf = "wf_wr_lane1"; cyc();
        wf_we = 2'b00; lat_wf = 18'h012EF; chk_wf = 1; tag_wf = "wf_rd_lane1"; cyc();
        wf_en = 0; wf_ssr = 1; lat_wf = SRV_WF; chk_wf = 1; tag_wf = "wf_ssr"; cyc();
        wf_ssr = 0;

        // NO_CHANGE: latch holds across a write
        nc_en = 1; nc_addr = 11'd1; lat_nc = 18'h15A; chk_nc = 1; tag_nc = "nc_rd1"; cyc();
        nc_addr = 11'd2; nc_we = 1; nc_di = 8'h33; nc_dip = 1;
        lat_nc = 18'h15A; chk_nc = 1; tag_nc = "nc_wr_hold"; cyc();
        nc_we = 0; lat_nc = 18'h133; chk_nc = 1; tag_nc = "nc_rd2"; cyc();

        // SSR with EN=0, then SSR concurrent with a write
        nc_en = 0; nc_ssr = 1; lat_nc = SRV_NC; chk_nc = 1; tag_nc = "nc_ssr"; cyc();
        nc_ssr = 0; lat_nc = SRV_NC; chk_nc = 1; tag_nc = "nc_ssr_hold"; cyc();
        nc_en = 1; nc_ssr = 1; nc_addr = 11'd7; nc_we = 1; nc_di = 8'h11; nc_dip = 0;
        lat_nc = SRV_NC; chk_nc = 1; tag_nc = "nc_ssr_wr"; cyc();
        nc_ssr = 0; nc_we = 0; lat_nc = 18'h011; chk_nc = 1; tag_nc = "nc_rd7"; cyc();
        nc_en = 0;

        // EN=0 blocks the write and holds the latch
        rf_en = 0; rf_we = 1; rf_addr = 11'd9; rf_di = 8'hFF; rf_dip = 0;
        lat_rf = 18'h0AA; chk_rf = 1; tag_rf = "rf_en0_hold"; cyc();
        rf_en = 1; rf_we = 0; lat_rf = 18'h15A; chk_rf = 1; tag_rf = "rf_rd9"; cyc();
        rf_en = 0;

        cyc();
        cyc();
        done = 1'b1;
        repeat (20) @(posedge clk);
        $display("FAIL drain_timeout: got queues pending expected empty");
        $fatal(1, "bench did not terminate");
    end

endmodule
